// File: rtl/gerador_jogo_if.sv
// Game-word bus between the controller (master) and the role dealer (slave).
interface gerador_jogo_if;
  logic       gerar;
  logic [4:0] seed;
  logic [2:0] jogador;
  logic [9:0] jogo;
  logic [1:0] classe;
  logic       pronto;
  logic       ocupado;
  logic [1:0] db_estado;

  modport master (
    output gerar, seed, jogador,
    input  jogo, classe, pronto, ocupado, db_estado
  );

  modport slave (
    input  gerar, seed, jogador,
    output jogo, classe, pronto, ocupado, db_estado
  );
endinterface

// File: rtl/gerador_jogo.sv
// PoliLobinho role dealer: shuffles the 5-card deck with a Fisher-Yates pass
// driven by a 16-bit Galois LFSR and publishes the result as a packed game word.
module gerador_jogo (
  input logic           clock,
  input logic           reset,
  gerador_jogo_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    EMBARALHA = 2'd1,
    PRONTO    = 2'd2
  } estado_t;

  // Deck slots p0..p4 = 1,2,3,0,0 packed as {p4,p3,p2,p1,p0}
  localparam logic [9:0]  BARALHO       = {2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
  localparam logic [10:0] SEMENTE_BAIXA = 11'h5A1;
  localparam logic [15:0] TAPS          = 16'hB400;

  estado_t         estado;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_prox;
  logic [2:0]      indice;
  logic [2:0]      alvo;
  logic [4:0][1:0] slots;
  logic [4:0][1:0] slots_troca;
  logic [4:0][1:0] jogo_q;
  logic            pronto_q;
  logic            ocupado_q;
  logic [1:0]      classe_c;

  // Swap target j = (lfsr[7:0] * (i+1)) >> 8, always <= i, plus the next LFSR value
  always_comb begin
    alvo      = 3'(({3'b000, lfsr[7:0]} * {8'h00, indice + 3'd1}) >> 8);
    lfsr_prox = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  end

  // Slot contents after exchanging positions i and j (no-op when they coincide)
  always_comb begin
    slots_troca         = slots;
    slots_troca[indice] = slots[alvo];
    slots_troca[alvo]   = slots[indice];
  end

  // Control FSM: accept a start, run four swap steps, then publish the game word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      lfsr      <= 16'h0001;
      indice    <= 3'd0;
      slots     <= '0;
      jogo_q    <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, PRONTO: begin
          if (bus.gerar) begin
            lfsr      <= {bus.seed, SEMENTE_BAIXA};
            slots     <= BARALHO;
            indice    <= 3'd4;
            estado    <= EMBARALHA;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b1;
          end
        end
        EMBARALHA: begin
          slots  <= slots_troca;
          lfsr   <= lfsr_prox;
          indice <= indice - 3'd1;
          if (indice == 3'd1) begin
            jogo_q    <= slots_troca;
            estado    <= PRONTO;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
          end
        end
        default: begin
          estado    <= OCIOSO;
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-player read port; indices beyond the last player read as class 0
  always_comb begin
    classe_c = 2'd0;
    case (bus.jogador)
      3'd0:    classe_c = jogo_q[0];
      3'd1:    classe_c = jogo_q[1];
      3'd2:    classe_c = jogo_q[2];
      3'd3:    classe_c = jogo_q[3];
      3'd4:    classe_c = jogo_q[4];
      default: classe_c = 2'd0;
    endcase
  end

  assign bus.jogo      = jogo_q;
  assign bus.classe    = classe_c;
  assign bus.pronto    = pronto_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.db_estado = estado;

endmodule
